// File: rtl/multicycle_control_if.sv
// Control-unit bus: instruction fetch, data-memory handshake, ALU flag, syscall
// handshake and every datapath control the sequencer drives.
interface multicycle_control_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              imem_valid;
    logic [DATA_W-1:0] imem_data;
    logic              dmem_ready;
    logic              zero;
    logic              syscall_ack;

    logic              imem_req;
    logic              pc_write;
    logic [1:0]        pc_src;
    logic              reg_dst1;
    logic              reg_dst2;
    logic              acc_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jal;
    logic              lwra;
    logic [1:0]        alu_src;
    logic [2:0]        alu_op;
    logic [4:0]        opcode;
    logic [DATA_W-1:0] imm;
    logic              syscall_req;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        input  imem_valid, imem_data, dmem_ready, zero, syscall_ack,
        output imem_req, pc_write, pc_src, reg_dst1, reg_dst2, acc_write,
               mem_to_reg, reg_write, mem_read, mem_write, branch, jal, lwra,
               alu_src, alu_op, opcode, imm, syscall_req, instr_count
    );

    modport slave (
        output imem_valid, imem_data, dmem_ready, zero, syscall_ack,
        input  imem_req, pc_write, pc_src, reg_dst1, reg_dst2, acc_write,
               mem_to_reg, reg_write, mem_read, mem_write, branch, jal, lwra,
               alu_src, alu_op, opcode, imm, syscall_req, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle sequencer for a byte-coded ISA: fetches one or two instruction
// bytes, executes in one cycle, and stretches memory and syscall phases on handshakes.
module multicycle_control #(
    parameter int         DATA_W = 8,
    parameter int         CNT_W  = 16,
    parameter logic [2:0] RA_SEL = 3'b011
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH1,
        S_FETCH2,
        S_EXEC,
        S_MEM,
        S_SYS
    } state_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] alu_src;
        logic       reg_dst1;
        logic       reg_dst2;
        logic       acc_write;
    } alu_ctl_t;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_NAND = 5'b01000;
    localparam logic [4:0] OP_SLT  = 5'b10000;
    localparam logic [4:0] OP_MOVE = 5'b11000;
    localparam logic [4:0] OP_SRL  = 5'b11001;
    localparam logic [4:0] OP_JRRA = 5'b11010;
    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [4:0] OP_SW   = 5'b11100;
    localparam logic [4:0] OP_ADDI = 5'b11101;
    localparam logic [4:0] OP_LW   = 5'b11110;
    localparam logic [4:0] OP_BEQ  = 5'b11111;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RA     = 2'b10;
    localparam logic [1:0] PC_JAL    = 2'b11;

    // Top two bits 11 mark a two-byte instruction with a full 5-bit opcode;
    // otherwise only those two bits select among the one-byte ALU ops.
    function automatic logic is_two_byte(input logic [DATA_W-1:0] b);
        return b[DATA_W-1:DATA_W-2] == 2'b11;
    endfunction

    function automatic logic [4:0] opcode_of(input logic [DATA_W-1:0] b);
        if (is_two_byte(b)) return b[DATA_W-1:DATA_W-5];
        else                return {b[DATA_W-1:DATA_W-2], 3'b000};
    endfunction

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [4:0] op;
    logic       ra_field;
    alu_ctl_t   alu_c;

    logic       fetch_req;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jal;
    logic       lwra;
    logic       syscall_req;

    assign op       = opcode_of(ir_q);
    assign ra_field = (ir_q[2:0] == RA_SEL);

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others; combinational blocks use blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH1;
            ir_q    <= '0;
            imm_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    // NOTE: every variable gets a hold/default value up front so no path through
    // the case statements leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        cnt_d   = cnt_q + CNT_W'(pc_write);
        case (state_q)
            S_FETCH1: begin
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_data;
                    imm_d   = '0;
                    state_d = is_two_byte(bus.imem_data) ? S_FETCH2 : S_EXEC;
                end
            end
            S_FETCH2: begin
                if (bus.imem_valid) begin
                    imm_d   = bus.imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op == OP_LW || op == OP_SW)     state_d = S_MEM;
                else if (op == OP_JRRA && !ra_field) state_d = S_SYS;
                else                                 state_d = S_FETCH1;
            end
            S_MEM:   if (bus.dmem_ready)  state_d = S_FETCH1;
            S_SYS:   if (bus.syscall_ack) state_d = S_FETCH1;
            default: state_d = S_FETCH1;
        endcase
    end

    // ALU/register-file steering for the latched opcode
    always_comb begin
        alu_c = '0;
        case (op)
            OP_ADD:  alu_c = '{3'b000, 2'b00, 1'b0, 1'b0, 1'b1};
            OP_NAND: alu_c = '{3'b010, 2'b00, 1'b0, 1'b0, 1'b1};
            OP_SLT:  alu_c = '{3'b011, 2'b00, 1'b0, 1'b0, 1'b1};
            OP_MOVE: alu_c = '{3'b101, 2'b00, 1'b0, 1'b0, 1'b0};
            OP_SRL:  alu_c = '{3'b100, 2'b01, 1'b0, 1'b0, 1'b1};
            OP_JRRA: alu_c = '{3'b101, 2'b00, 1'b1, 1'b0, 1'b0};
            OP_JAL:  alu_c = '{3'b101, 2'b00, 1'b0, 1'b0, 1'b0};
            OP_SW:   alu_c = '{3'b000, 2'b11, 1'b1, 1'b1, 1'b0};
            OP_ADDI: alu_c = '{3'b000, 2'b10, 1'b1, 1'b0, 1'b1};
            OP_LW:   alu_c = '{3'b000, 2'b11, 1'b0, 1'b1, 1'b0};
            OP_BEQ:  alu_c = '{3'b001, 2'b00, 1'b1, 1'b1, 1'b0};
            default: alu_c = '0;
        endcase
    end

    // Output logic
    always_comb begin
        fetch_req   = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SEQ;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        jal         = 1'b0;
        lwra        = 1'b0;
        syscall_req = 1'b0;
        case (state_q)
            S_FETCH1, S_FETCH2: fetch_req = 1'b1;
            S_EXEC: begin
                case (op)
                    OP_LW, OP_SW: ;
                    OP_MOVE: begin
                        reg_write  = 1'b1;
                        mem_to_reg = 1'b1;
                        pc_write   = 1'b1;
                    end
                    OP_JRRA: begin
                        if (ra_field) begin
                            pc_src   = PC_RA;
                            pc_write = 1'b1;
                        end
                    end
                    OP_JAL: begin
                        pc_src    = PC_JAL;
                        jal       = 1'b1;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    OP_BEQ: begin
                        branch   = 1'b1;
                        pc_src   = bus.zero ? PC_BRANCH : PC_SEQ;
                        pc_write = 1'b1;
                    end
                    default: pc_write = 1'b1;
                endcase
            end
            S_MEM: begin
                if (op == OP_LW) begin
                    mem_read = 1'b1;
                    if (bus.dmem_ready) begin
                        reg_write = 1'b1;
                        lwra      = ra_field;
                        jal       = ra_field;
                    end
                end else begin
                    mem_write = 1'b1;
                end
                pc_write = bus.dmem_ready;
            end
            S_SYS: begin
                syscall_req = 1'b1;
                pc_write    = bus.syscall_ack;
            end
            default: ;
        endcase
    end

    // The fetch request is the only strobe active in the reset state, so gate it.
    assign bus.imem_req    = fetch_req & rst_n;
    assign bus.pc_write    = pc_write;
    assign bus.pc_src      = pc_src;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.reg_write   = reg_write;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.branch      = branch;
    assign bus.jal         = jal;
    assign bus.lwra        = lwra;
    assign bus.syscall_req = syscall_req;

    assign bus.alu_op    = (state_q == S_EXEC || state_q == S_MEM) ? alu_c.alu_op   : 3'b000;
    assign bus.alu_src   = (state_q == S_EXEC || state_q == S_MEM) ? alu_c.alu_src  : 2'b00;
    assign bus.reg_dst1  = (state_q == S_EXEC || state_q == S_MEM) & alu_c.reg_dst1;
    assign bus.reg_dst2  = (state_q == S_EXEC || state_q == S_MEM) & alu_c.reg_dst2;
    assign bus.acc_write = (state_q == S_EXEC) & alu_c.acc_write;

    assign bus.opcode      = op;
    assign bus.imm         = imm_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: table of single-instruction vectors
// plus hand-written sequences for memory, syscall, reset-abort and counter wrap.
module tb_multicycle_control;

    localparam int DW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    multicycle_control #(.DATA_W(DW), .CNT_W(CW), .RA_SEL(3'b011)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       two;
        logic       zero;
        logic [4:0] op;
        logic [2:0] alu_op;
        logic [1:0] alu_src;
        logic       rd1;
        logic       rd2;
        logic       acc;
        logic       rw;
        logic       m2r;
        logic [1:0] pc_src;
        logic       br;
        logic       jl;
    } vec_t;

    vec_t vecs [11];

    int n_tests = 0;
    int n_fail  = 0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {alu_op, alu_src, reg_dst1, reg_dst2, acc_write, reg_write, mem_to_reg,
    //  pc_write, pc_src, branch, jal, lwra, mem_read, mem_write, syscall_req, imem_req}
    function automatic logic [19:0] ctl();
        return {bus.alu_op, bus.alu_src, bus.reg_dst1, bus.reg_dst2, bus.acc_write,
                bus.reg_write, bus.mem_to_reg, bus.pc_write, bus.pc_src, bus.branch,
                bus.jal, bus.lwra, bus.mem_read, bus.mem_write, bus.syscall_req,
                bus.imem_req};
    endfunction

    // {acc_write, reg_write, mem_to_reg, pc_write, pc_src, branch, jal, lwra,
    //  mem_read, mem_write, syscall_req, imem_req}
    function automatic logic [12:0] stb();
        return {bus.acc_write, bus.reg_write, bus.mem_to_reg, bus.pc_write, bus.pc_src,
                bus.branch, bus.jal, bus.lwra, bus.mem_read, bus.mem_write,
                bus.syscall_req, bus.imem_req};
    endfunction

    function automatic logic [19:0] exec_exp(input vec_t v);
        return {v.alu_op, v.alu_src, v.rd1, v.rd2, v.acc, v.rw, v.m2r, 1'b1, v.pc_src,
                v.br, v.jl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    // Starts at a negedge in FETCH1; ends #1 after the negedge following pc_write.
    task automatic run_vec(input vec_t v);
        bus.imem_valid = 1'b1;
        bus.imem_data  = v.b0;
        bus.zero       = v.zero;
        @(negedge clk);
        if (v.two) begin
            bus.imem_data = v.b1;
            @(negedge clk);
        end
        bus.imem_valid = 1'b0;
        bus.imem_data  = '0;
        #1;
        check({v.name, "_exec_ctl"}, 32'(ctl()), 32'(exec_exp(v)));
        check({v.name, "_opcode"}, 32'(bus.opcode), 32'(v.op));
        check({v.name, "_imm"}, 32'(bus.imm), v.two ? 32'(v.b1) : 32'd0);
        exp_cnt++;
        @(negedge clk);
        #1;
        check({v.name, "_count"}, 32'(bus.instr_count), 32'(exp_cnt));
        check({v.name, "_back_fetch"}, 32'(stb()), 32'h1);
        bus.zero = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        //         name         b0     b1     two  z    op        alu    src    d1 d2 acc rw m2r pc     br jl
        vecs[0]  = '{"add",     8'h05, 8'h00, 0, 0, 5'b00000, 3'b000, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0};
        vecs[1]  = '{"nand",    8'h41, 8'h00, 0, 0, 5'b01000, 3'b010, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0};
        vecs[2]  = '{"slt",     8'h82, 8'h00, 0, 0, 5'b10000, 3'b011, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0};
        vecs[3]  = '{"move",    8'hC1, 8'h33, 1, 0, 5'b11000, 3'b101, 2'b00, 0, 0, 0, 1, 1, 2'b00, 0, 0};
        vecs[4]  = '{"srl",     8'hCA, 8'h02, 1, 0, 5'b11001, 3'b100, 2'b01, 0, 0, 1, 0, 0, 2'b00, 0, 0};
        vecs[5]  = '{"jrra",    8'hD3, 8'h5A, 1, 0, 5'b11010, 3'b101, 2'b00, 1, 0, 0, 0, 0, 2'b10, 0, 0};
        vecs[6]  = '{"jal",     8'hD8, 8'h40, 1, 0, 5'b11011, 3'b101, 2'b00, 0, 0, 0, 1, 0, 2'b11, 0, 1};
        vecs[7]  = '{"addi",    8'hE9, 8'h7F, 1, 0, 5'b11101, 3'b000, 2'b10, 1, 0, 1, 0, 0, 2'b00, 0, 0};
        vecs[8]  = '{"beq_z1",  8'hF8, 8'h04, 1, 1, 5'b11111, 3'b001, 2'b00, 1, 1, 0, 0, 0, 2'b01, 1, 0};
        vecs[9]  = '{"beq_z0",  8'hF8, 8'h04, 1, 0, 5'b11111, 3'b001, 2'b00, 1, 1, 0, 0, 0, 2'b00, 1, 0};
        vecs[10] = '{"add_imm0",8'h07, 8'h00, 0, 0, 5'b00000, 3'b000, 2'b00, 0, 0, 1, 0, 0, 2'b00, 0, 0};

        bus.imem_valid  = 1'b0;
        bus.imem_data   = '0;
        bus.dmem_ready  = 1'b0;
        bus.zero        = 1'b0;
        bus.syscall_ack = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_ctl", 32'(ctl()), 32'h0);
        check("rst_opcode_imm", 32'({bus.opcode, bus.imm}), 32'h0);
        check("rst_count", 32'(bus.instr_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_req", 32'(stb()), 32'h1);

        // sw aborted by reset while waiting in MEM
        bus.imem_valid = 1'b1;
        bus.imem_data  = 8'hE1;
        @(negedge clk);
        bus.imem_data = 8'h20;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        #1;
        check("sw_exec_ctl", 32'(ctl()), 32'(20'b000_11_1_1_0_0_0_0_00_0_0_0_0_0_0_0));
        @(negedge clk);
        #1;
        check("sw_mem_write", 32'(stb()), 32'(13'b0_0_0_0_00_0_0_0_0_1_0_0));
        #2;
        rst_n = 1'b0;
        #1;
        check("sw_abort_strobes", 32'(stb()), 32'h0);
        check("sw_abort_count", 32'(bus.instr_count), 32'(exp_cnt));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("sw_abort_fetch1", 32'(stb()), 32'h1);
        check("sw_abort_count2", 32'(bus.instr_count), 32'(exp_cnt));

        // Table of single-pass instructions
        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // lw $ra with fetch stalls and a 3-cycle data-memory wait
        bus.imem_valid = 1'b1;
        bus.imem_data  = 8'hF3;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        #1;
        check("lw_stall1_req", 32'(stb()), 32'h1);
        @(negedge clk);
        #1;
        check("lw_stall2_req", 32'(stb()), 32'h1);
        bus.imem_valid = 1'b1;
        bus.imem_data  = 8'h10;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        #1;
        check("lw_exec_ctl", 32'(ctl()), 32'(20'b000_11_0_1_0_0_0_0_00_0_0_0_0_0_0_0));
        check("lw_imm", 32'(bus.imm), 32'h10);
        check("lw_opcode", 32'(bus.opcode), 32'(5'b11110));
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("lw_wait%0d", i), 32'(stb()), 32'(13'b0_0_0_0_00_0_0_0_1_0_0_0));
            @(negedge clk);
        end
        bus.dmem_ready = 1'b1;
        #1;
        check("lw_ready", 32'(stb()), 32'(13'b0_1_0_1_00_0_1_1_1_0_0_0));
        exp_cnt++;
        @(negedge clk);
        bus.dmem_ready = 1'b0;
        #1;
        check("lw_count", 32'(bus.instr_count), 32'(exp_cnt));
        check("lw_back_fetch", 32'(stb()), 32'h1);

        // syscall with ack held low for 5 cycles
        bus.imem_valid = 1'b1;
        bus.imem_data  = 8'hD2;
        @(negedge clk);
        bus.imem_data = 8'h00;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        #1;
        check("sys_exec", 32'(stb()), 32'h0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("sys_wait%0d", i), 32'(stb()), 32'(13'b0_0_0_0_00_0_0_0_0_0_1_0));
            @(negedge clk);
        end
        bus.syscall_ack = 1'b1;
        #1;
        check("sys_ack", 32'(stb()), 32'(13'b0_0_0_1_00_0_0_0_0_0_1_0));
        exp_cnt++;
        @(negedge clk);
        bus.syscall_ack = 1'b0;
        #1;
        check("sys_count", 32'(bus.instr_count), 32'(exp_cnt));
        check("sys_back_fetch", 32'(stb()), 32'h1);

        // syscall with ack already high on entry to SYS
        bus.syscall_ack = 1'b1;
        bus.imem_valid  = 1'b1;
        bus.imem_data   = 8'hD2;
        @(negedge clk);
        bus.imem_data = 8'h55;
        @(negedge clk);
        bus.imem_valid = 1'b0;
        #1;
        check("sys_pre_exec", 32'(stb()), 32'h0);
        @(negedge clk);
        #1;
        check("sys_pre_ack", 32'(stb()), 32'(13'b0_0_0_1_00_0_0_0_0_0_1_0));
        exp_cnt++;
        @(negedge clk);
        bus.syscall_ack = 1'b0;
        #1;
        check("sys_pre_count", 32'(bus.instr_count), 32'(exp_cnt));
        check("sys_pre_back_fetch", 32'(stb()), 32'h1);

        // Counter wrap: reset, 15 instructions to all-ones, one more to zero
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        check("wrap_rst_count", 32'(bus.instr_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 15; i++) run_vec(vecs[0]);
        check("cnt_all_ones", 32'(bus.instr_count), 32'hF);
        run_vec(vecs[0]);
        check("cnt_wrap", 32'(bus.instr_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
